mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory between the fetch stage (read-only) and the MEM stage (load/store).
- Issues one memory transaction at a time through a req/ready handshake and returns registered read data with a one-cycle valid pulse.
- Drives per-requester stall signals to the pipeline hazard logic.
- Data requests win by default; a starvation counter forces a fetch grant after STARVE_MAX consecutive data grants taken while a fetch was waiting.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage.
// Optional stall performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_mem_stall
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              data_valid_q, data_valid_d;
  logic              served_d_q, served_d_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              grant_i, grant_d;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    data_rdata_d = data_rdata_q;
    if_valid_d   = 1'b0;
    data_valid_d = 1'b0;
    served_d_d   = served_d_q;
    starve_cnt_d = starve_cnt_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req && (!data_req || starve_cnt_q == STARVE_LIM)) grant_i = 1'b1;
        else if (data_req)                                        grant_d = 1'b1;
      end
      // The requester just served still shows its old req, so only the other side competes.
      DONE: begin
        if (served_d_q) grant_i = if_req;
        else            grant_d = data_req;
        state_d = IDLE;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          state_d    = DONE;
          served_d_d = (state_q == BUSY_D);
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) data_rdata_d = mem_rdata;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_i) begin
      state_d      = BUSY_I;
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = if_addr;
      starve_cnt_d = '0;
    end else if (grant_d) begin
      state_d     = BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = data_we;
      mem_addr_d  = data_addr;
      mem_wdata_d = data_wdata;
      if (if_req && starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      data_rdata_q <= '0;
      if_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
      served_d_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      data_rdata_q <= data_rdata_d;
      if_valid_q   <= if_valid_d;
      data_valid_q <= data_valid_d;
      served_d_q   <= served_d_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign data_rdata = data_rdata_q;
  assign if_valid   = if_valid_q;
  assign data_valid = data_valid_q;
  assign stall_if   = if_req & ~if_valid_q;
  assign stall_mem  = data_req & ~data_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  always_comb begin
    perf_if_d  = perf_if_q;
    perf_mem_d = perf_mem_q;
    if (stall_if)  perf_if_d  = perf_if_q + 32'd1;
    if (stall_mem) perf_mem_d = perf_mem_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_if_q  <= perf_if_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign perf_if_stall  = perf_if_q;
  assign perf_mem_stall = perf_mem_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard on valid pulses,
// and scripted collision / starvation / reset sequences against a behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, data_req, data_we;
  logic [31:0] if_addr, data_addr, data_wdata;
  logic [31:0] if_rdata, data_rdata;
  logic        if_valid, data_valid, stall_if, stall_mem;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_mem_stall;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ws = 0;
  int unsigned wcnt = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] q_if[$];
  logic [31:0] q_d[$];

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned ws;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .stall_if(stall_if),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: ready after ws wait cycles, settles well before the next rising edge.
  always @(posedge clk) begin
    #2;
    mem_ready = 1'b0;
    if (!mem_req) wcnt = 0;
    else if (wcnt < ws) wcnt++;
    else begin
      mem_ready = 1'b1;
      wcnt = 0;
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr;
    end
  end

  // Scoreboard: every valid pulse consumes one expected value.
  always @(negedge clk) begin
    if (if_valid) begin
      if (q_if.size() == 0) check("if_unexpected_valid", 64'(1), 64'(0));
      else check("if_rdata", 64'(if_rdata), 64'(q_if.pop_front()));
    end
    if (data_valid) begin
      if (q_d.size() == 0) check("data_unexpected_valid", 64'(1), 64'(0));
      else check("data_rdata", 64'(data_rdata), 64'(q_d.pop_front()));
    end
  end

  task automatic run_row(input vec_t v);
    int unsigned lat;
    bit got;
    logic vld, stl;
    lat = 2 + v.ws;
    got = 1'b0;
    ws = v.ws;
    if (v.fetch) begin
      if_addr = v.addr; if_req = 1'b1; q_if.push_back(v.exp);
    end else begin
      data_we = v.we; data_addr = v.addr; data_wdata = v.wdata; data_req = 1'b1;
      q_d.push_back(v.exp);
    end
    for (int k = 1; k <= int'(lat) + 20 && !got; k++) begin
      @(negedge clk);
      vld = v.fetch ? if_valid : data_valid;
      stl = v.fetch ? stall_if : stall_mem;
      if (k < int'(lat)) begin
        check("busy_req", 64'(mem_req), 64'(1));
        check("busy_addr", 64'(mem_addr), 64'(v.addr));
        check("busy_we", 64'(mem_we), 64'(v.fetch ? 1'b0 : v.we));
        check("busy_stall", 64'(stl), 64'(1));
        if (!v.fetch && v.we) check("busy_wdata", 64'(mem_wdata), 64'(v.wdata));
      end
      if (vld) begin
        got = 1'b1;
        check("latency", 64'(k), 64'(lat));
        check("done_stall", 64'(stl), 64'(0));
        check("done_req", 64'(mem_req), 64'(0));
      end
    end
    if (!got) check("valid_timeout", 64'(0), 64'(1));
    if_req = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic starve_run();
    bit          glog[$];
    bit          prev_req;
    bit          f_done;
    int unsigned dgot;
    int unsigned lead;
    prev_req = 1'b0; f_done = 1'b0; dgot = 0; lead = 0;
    ws = 0;
    if_addr = 32'h104; if_req = 1'b1; q_if.push_back(32'h00a00113);
    data_we = 1'b0; data_addr = 32'h48; data_req = 1'b1; q_d.push_back(32'hCAFEF00D);
    for (int k = 0; k < 80 && dgot < 5; k++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        glog.push_back(mem_addr == 32'h104);
        if (mem_addr == 32'h104) check("starve_fetch_we", 64'(mem_we), 64'(0));
      end
      prev_req = mem_req;
      if (if_valid) begin
        f_done = 1'b1;
        if_req = 1'b0;
      end
      if (data_valid) begin
        dgot++;
        if (dgot >= 5) data_req = 1'b0;
        else q_d.push_back(32'hCAFEF00D);
        if (!f_done) if_req = 1'b0;
      end else if (!f_done && !if_req) begin
        if_req = 1'b1;
      end
    end
    check("starve_data_count", 64'(dgot), 64'(5));
    check("starve_grant_count", 64'(glog.size()), 64'(6));
    foreach (glog[i]) if (glog[i] == 1'b0 && lead == i) lead++;
    check("starve_data_before_fetch", 64'(lead), 64'(4));
    if (glog.size() == 6) check("starve_last_is_data", 64'(glog[5]), 64'(0));
    if_req = 1'b0;
    data_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{fetch: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0,        ws: 0, exp: 32'h00500093};
    vecs[1] = '{fetch: 1'b0, we: 1'b1, addr: 32'h040, wdata: 32'hDEADBEEF, ws: 0, exp: 32'h00000000};
    vecs[2] = '{fetch: 1'b0, we: 1'b0, addr: 32'h040, wdata: 32'h0,        ws: 0, exp: 32'hDEADBEEF};
    vecs[3] = '{fetch: 1'b1, we: 1'b0, addr: 32'h104, wdata: 32'h0,        ws: 3, exp: 32'h00a00113};
    vecs[4] = '{fetch: 1'b0, we: 1'b1, addr: 32'h044, wdata: 32'h12345678, ws: 1, exp: 32'hDEADBEEF};
    vecs[5] = '{fetch: 1'b0, we: 1'b0, addr: 32'h044, wdata: 32'h0,        ws: 2, exp: 32'h12345678};
    vecs[6] = '{fetch: 1'b0, we: 1'b0, addr: 32'h048, wdata: 32'h0,        ws: 0, exp: 32'hCAFEF00D};

    mem_model[32'h100] = 32'h00500093;
    mem_model[32'h104] = 32'h00a00113;
    mem_model[32'h048] = 32'hCAFEF00D;

    rst = 1'b0; if_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    if_addr = '0; data_addr = '0; data_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_valids", 64'({if_valid, data_valid}), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'({if_rdata, data_rdata}), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_row(vecs[i]);

    // Collision: data first, then fetch granted straight out of DONE.
    ws = 0;
    if_addr = 32'h100; if_req = 1'b1; q_if.push_back(32'h00500093);
    data_we = 1'b0; data_addr = 32'h040; data_req = 1'b1; q_d.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("coll_first_addr", 64'(mem_addr), 64'(32'h040));
    check("coll_first_req", 64'(mem_req), 64'(1));
    check("coll_stall_if", 64'(stall_if), 64'(1));
    @(negedge clk);
    check("coll_data_valid", 64'(data_valid), 64'(1));
    check("coll_done_req", 64'(mem_req), 64'(0));
    data_req = 1'b0;
    @(negedge clk);
    check("coll_direct_req", 64'(mem_req), 64'(1));
    check("coll_direct_addr", 64'(mem_addr), 64'(32'h100));
    @(negedge clk);
    check("coll_if_valid", 64'(if_valid), 64'(1));
    if_req = 1'b0;
    @(negedge clk);

    starve_run();
    starve_run();

    // Reset while a slow store is in BUSY_D.
    ws = 5;
    data_we = 1'b1; data_addr = 32'h080; data_wdata = 32'h55AA55AA; data_req = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_busy_req", 64'(mem_req), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 64'(mem_req), 64'(0));
    check("mid_rst_valids", 64'({if_valid, data_valid}), 64'(0));
    check("mid_rst_addr", 64'(mem_addr), 64'(0));
    data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_idle_req", 64'(mem_req), 64'(0));
    end

    check("sb_if_empty", 64'(q_if.size()), 64'(0));
    check("sb_data_empty", 64'(q_d.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
